// File: rtl/aes_iter_encrypt_core.sv
// Iterative AES-128/192/256 encryption core: one or two rounds per clock over a
// registered 128-bit state, valid/ready handshakes on input and output.
module aes_iter_encrypt_core #(
  parameter int KEY_BITS         = 128,
  parameter int ROUNDS_PER_CYCLE = 1,
  localparam int NR   = (KEY_BITS == 256) ? 14 : (KEY_BITS == 192) ? 12 : 10,
  localparam int ITER = NR / ROUNDS_PER_CYCLE,
  localparam int KS_W = (NR + 1) * 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [0:127]    in_block,
  input  logic [0:KS_W-1] key_schedule,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:127]    out_block,
  output logic            busy
);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256) ||
      !(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2)) begin : g_bad_params
    $error("aes_iter_encrypt_core: unsupported KEY_BITS=%0d ROUNDS_PER_CYCLE=%0d",
           KEY_BITS, ROUNDS_PER_CYCLE);
  end

  localparam logic [3:0] NR4      = 4'(NR);
  localparam logic [3:0] LAST_RND = 4'((ITER - 1) * ROUNDS_PER_CYCLE + 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] rk_in,
                                             input logic last);
    logic [0:127] sb;
    logic [0:127] sr;
    logic [0:127] mc;
    logic [7:0]   a0, a1, a2, a3;
    for (int k = 0; k < 16; k++) sb[k*8 +: 8] = SBOX[s[k*8 +: 8]];
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++)
        sr[c*32 + i*8 +: 8] = sb[((c + i) % 4)*32 + i*8 +: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[c*32 +: 8];
      a1 = sr[c*32 + 8 +: 8];
      a2 = sr[c*32 + 16 +: 8];
      a3 = sr[c*32 + 24 +: 8];
      mc[c*32 +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[c*32 + 8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[c*32 + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[c*32 + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return (last ? sr : mc) ^ rk_in;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm, fsm_next;
  logic [0:127] state, stage0, round_out;
  logic [3:0]   rnd;
  logic         accept, last_step;
  logic [0:127] rk [16];

  // Padding to 16 entries keeps every 4-bit round index in range.
  for (genvar r = 0; r < 16; r++) begin : g_rk
    if (r <= NR) begin : g_used
      assign rk[r] = key_schedule[r*128 +: 128];
    end else begin : g_pad
      assign rk[r] = '0;
    end
  end

  assign accept    = in_valid && in_ready;
  assign last_step = (fsm == RUN) && (rnd == LAST_RND);
  assign stage0    = aes_round(state, rk[rnd], rnd == NR4);

  if (ROUNDS_PER_CYCLE == 2) begin : g_two
    logic [3:0] rnd_b;
    assign rnd_b     = rnd + 4'd1;
    assign round_out = aes_round(stage0, rk[rnd_b], rnd_b == NR4);
  end else begin : g_one
    assign round_out = stage0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (accept) fsm_next = RUN;
      RUN:     if (last_step) fsm_next = DONE;
      DONE:    if (out_ready) fsm_next = in_valid ? RUN : IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_block = '0;
    case (fsm)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        busy      = 1'b1;
        out_block = state;
      end
      default: ;
    endcase
  end

  // rnd parks at 0 after the final round so it never exceeds NR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      rnd   <= '0;
    end else if (accept) begin
      state <= in_block ^ rk[0];
      rnd   <= 4'd1;
    end else if (fsm == RUN) begin
      state <= round_out;
      rnd   <= last_step ? 4'd0 : rnd + 4'(ROUNDS_PER_CYCLE);
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) rnd <= NR4);

endmodule

// File: tb/tb_aes_iter_encrypt_core.sv
// Bench for aes_iter_encrypt_core: FIPS-197 vectors and random blocks on five
// parameter sets, checked against a byte-level AES model, plus protocol sequences.
module tb_aes_iter_encrypt_core;

  logic clk, rst_n;
  logic a_valid, a_out_ready, ax_valid;
  logic [0:127] a_block, ax_block;
  logic [0:1407] ks_a, ks_b;
  logic [0:1663] ks_c;
  logic [0:1919] ks_d;
  logic [4:0] rdy_all, ov_all, busy_all;
  logic [0:127] ob_all [5];

  int total, bad;
  logic [7:0] sbox_tab [256];
  int exp_lat [5] = '{10, 5, 12, 14, 7};
  int nk_of   [5] = '{4, 4, 6, 8, 8};

  aes_iter_encrypt_core #(.KEY_BITS(128), .ROUNDS_PER_CYCLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(rdy_all[0]), .in_block(a_block),
    .key_schedule(ks_a), .out_valid(ov_all[0]), .out_ready(a_out_ready), .out_block(ob_all[0]),
    .busy(busy_all[0]));
  aes_iter_encrypt_core #(.KEY_BITS(128), .ROUNDS_PER_CYCLE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(ax_valid), .in_ready(rdy_all[1]), .in_block(ax_block),
    .key_schedule(ks_b), .out_valid(ov_all[1]), .out_ready(1'b1), .out_block(ob_all[1]),
    .busy(busy_all[1]));
  aes_iter_encrypt_core #(.KEY_BITS(192), .ROUNDS_PER_CYCLE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(ax_valid), .in_ready(rdy_all[2]), .in_block(ax_block),
    .key_schedule(ks_c), .out_valid(ov_all[2]), .out_ready(1'b1), .out_block(ob_all[2]),
    .busy(busy_all[2]));
  aes_iter_encrypt_core #(.KEY_BITS(256), .ROUNDS_PER_CYCLE(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(ax_valid), .in_ready(rdy_all[3]), .in_block(ax_block),
    .key_schedule(ks_d), .out_valid(ov_all[3]), .out_ready(1'b1), .out_block(ob_all[3]),
    .busy(busy_all[3]));
  aes_iter_encrypt_core #(.KEY_BITS(256), .ROUNDS_PER_CYCLE(2)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(ax_valid), .in_ready(rdy_all[4]), .in_block(ax_block),
    .key_schedule(ks_d), .out_valid(ov_all[4]), .out_ready(1'b1), .out_block(ob_all[4]),
    .busy(busy_all[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box built from the field inverse and the affine map, independent of any table.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = (x == 8'h00) ? 8'h00 : 8'h01;
    if (x != 8'h00) for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    s = inv ^ 8'h63;
    for (int n = 1; n <= 4; n++) s = s ^ ((inv << n) | (inv >> (8 - n)));
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  function automatic logic [0:1919] expand_key(input logic [0:255] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [0:1919] ks;
    ks = '0; rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) w[i] = key[i*32 +: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = gmul(rcon, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
      ks[i*32 +: 32] = w[i];
    end
    return ks;
  endfunction

  function automatic logic [0:127] aes_ref(input logic [0:127] pt, input logic [0:1919] ks, input int nr);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] m [4][4];
    logic [7:0] acc;
    logic [0:127] out;
    m = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
          '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = pt[(c*4 + r)*8 +: 8] ^ ks[(c*4 + r)*8 +: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbox_tab[s[r][(c + r) % 4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[r][k], t[k][c]);
          s[r][c] = (rd == nr) ? t[r][c] : acc;
        end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ ks[rd*128 + (c*4 + r)*8 +: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) out[(c*4 + r)*8 +: 8] = s[r][c];
    return out;
  endfunction

  task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // One block into every core sized for this key; latency and ciphertext checked per core.
  task automatic apply_stimulus(input logic [0:255] key, input int nk, input logic [0:127] pt,
                                input logic [0:127] ct, input string tag);
    logic [0:1919] ks;
    int lat [5];
    logic [0:127] got [5];
    ks = expand_key(key, nk);
    if (nk == 4) begin ks_a = ks[0:1407]; ks_b = ks[0:1407]; end
    else if (nk == 6) ks_c = ks[0:1663];
    else ks_d = ks;
    for (int j = 0; j < 5; j++) begin lat[j] = 0; got[j] = '0; end
    a_block = pt; ax_block = pt; a_valid = 1'b1; ax_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; ax_valid = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 5; j++)
        if (ov_all[j] && lat[j] == 0) begin lat[j] = n; got[j] = ob_all[j]; end
    end
    for (int j = 0; j < 5; j++)
      if (nk_of[j] == nk) begin
        check_output($sformatf("%s_dut%0d_latency", tag, j), 128'(lat[j]), 128'(exp_lat[j]));
        check_output($sformatf("%s_dut%0d_block", tag, j), got[j], ct);
      end
  endtask

  typedef struct {
    logic [0:255] key;
    int           nk;
    logic [0:127] pt;
    logic [0:127] ct;
  } vec_t;

  initial begin
    vec_t vecs [4];
    logic [0:255] key;
    logic [0:1919] ks;
    logic [0:127] blk [4];
    logic [0:127] expct [4];
    logic [0:127] p, q, exp_p, exp_q;
    int out_cyc [4];
    int outs, idx, viol, n, stable_bad, ready_bad, nk;
    bit acc;

    total = 0; bad = 0;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

    vecs[0] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4,
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{{128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4,
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{{192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6,
                128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    vecs[3] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};

    rst_n = 1'b0; a_valid = 1'b0; ax_valid = 1'b0; a_out_ready = 1'b1;
    a_block = '0; ax_block = '0; ks_a = '0; ks_b = '0; ks_c = '0; ks_d = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_out_valid", 128'(ov_all), 128'h0);
    check_output("reset_busy", 128'(busy_all), 128'h0);
    check_output("reset_in_ready", 128'(rdy_all), 128'h1f);
    check_output("reset_out_block", ob_all[0], 128'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++)
      apply_stimulus(vecs[v].key, vecs[v].nk, vecs[v].pt, vecs[v].ct, $sformatf("fips%0d", v));

    for (int r = 0; r < 6; r++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      nk = 4 + 2 * (r % 3);
      apply_stimulus(key, nk, p, aes_ref(p, expand_key(key, nk), nk + 6), $sformatf("rand%0d", r));
    end

    // Back-to-back stream through DONE with in_valid and out_ready held high.
    ks = expand_key(vecs[0].key, 4);
    ks_a = ks[0:1407];
    blk[0] = vecs[0].pt;
    for (int k = 1; k < 4; k++) blk[k] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) begin expct[k] = aes_ref(blk[k], ks, 10); out_cyc[k] = 0; end
    outs = 0; idx = 0; viol = 0;
    a_block = blk[0]; a_valid = 1'b1; a_out_ready = 1'b1;
    for (int cyc = 1; cyc <= 100 && outs < 4; cyc++) begin
      acc = a_valid && rdy_all[0];
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) a_block = blk[idx];
        else a_valid = 1'b0;
      end
      if (ov_all[0]) begin
        out_cyc[outs] = cyc;
        check_output($sformatf("b2b_block%0d", outs), ob_all[0], expct[outs]);
        outs++;
      end
      if (rdy_all[0] && !ov_all[0] && a_valid && idx > 0) viol++;
    end
    a_valid = 1'b0;
    check_output("b2b_count", 128'(outs), 128'd4);
    for (int k = 0; k < 3; k++)
      check_output($sformatf("b2b_spacing%0d", k), 128'(out_cyc[k+1] - out_cyc[k]), 128'd11);
    check_output("b2b_in_ready_outside_done", 128'(viol), 128'd0);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: result held for 20 cycles while a new block waits.
    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    ks = expand_key(key, 4);
    ks_a = ks[0:1407];
    p = {$urandom, $urandom, $urandom, $urandom};
    q = {$urandom, $urandom, $urandom, $urandom};
    exp_p = aes_ref(p, ks, 10);
    exp_q = aes_ref(q, ks, 10);
    a_block = p; a_valid = 1'b1; a_out_ready = 1'b0;
    @(posedge clk); #1;
    a_valid = 1'b0;
    n = 0;
    while (!ov_all[0] && n < 20) begin @(posedge clk); #1; n++; end
    check_output("bp_latency", 128'(n), 128'd10);
    a_block = q; a_valid = 1'b1;
    stable_bad = 0; ready_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (!ov_all[0] || ob_all[0] !== exp_p) stable_bad++;
      if (rdy_all[0]) ready_bad++;
    end
    check_output("bp_held_block", ob_all[0], exp_p);
    check_output("bp_unstable_cycles", 128'(stable_bad), 128'd0);
    check_output("bp_in_ready_cycles", 128'(ready_bad), 128'd0);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check_output("bp_release_out_valid", 128'(ov_all[0]), 128'd0);
    check_output("bp_release_busy", 128'(busy_all[0]), 128'd1);
    n = 0;
    while (!ov_all[0] && n < 20) begin @(posedge clk); #1; n++; end
    check_output("bp_next_latency", 128'(n), 128'd10);
    check_output("bp_next_block", ob_all[0], exp_q);
    @(posedge clk); #1;

    // Reset in the middle of a run drops the block.
    ks = expand_key(vecs[0].key, 4);
    ks_a = ks[0:1407];
    a_block = vecs[0].pt; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output("rst_busy_before", 128'(busy_all[0]), 128'd1);
    #1 rst_n = 1'b0;
    #1;
    check_output("rst_out_valid", 128'(ov_all[0]), 128'd0);
    check_output("rst_busy", 128'(busy_all[0]), 128'd0);
    check_output("rst_in_ready", 128'(rdy_all[0]), 128'd1);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin @(posedge clk); #1; if (ov_all[0]) n++; end
    check_output("rst_no_emit", 128'(n), 128'd0);
    apply_stimulus(vecs[0].key, 4, vecs[0].pt, vecs[0].ct, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
